// File: rtl/neighborhood_sweep_ctrl_pkg.sv
// Shared types and constants for the 3x3 neighbourhood sweep controller.
// Port k of the window maps to offset (dx,dy) = (k%3-1, k/3-1); port 4 is the centre cell.
package neighborhood_sweep_ctrl_pkg;

    localparam int unsigned NPORTS      = 9;
    localparam int unsigned CENTRE_PORT = 4;
    localparam int unsigned GEN_W       = 16;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT    = 3'd2,
        S_CAPTURE = 3'd3,
        S_OFFER   = 3'd4,
        S_RESULT  = 3'd5,
        S_WRITE   = 3'd6,
        S_DONE    = 3'd7
    } state_t;

    // Row (dy+1) and column (dx+1) selectors of window port k.
    function automatic logic [1:0] port_row(input int unsigned k);
        return 2'(k / 3);
    endfunction

    function automatic logic [1:0] port_col(input int unsigned k);
        return 2'(k % 3);
    endfunction

endpackage

// File: rtl/neighborhood_sweep_ctrl_window_addr_gen.sv
// Combinational 3x3 window address generator on a toroidal grid.
// A dimension of size 1 wraps every neighbour back onto the cell itself.
module neighborhood_sweep_ctrl_window_addr_gen
    import neighborhood_sweep_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned GRID_W     = 8,
    parameter int unsigned GRID_H     = 8,
    parameter int unsigned XW         = 3,
    parameter int unsigned YW         = 3
) (
    input  logic [XW-1:0]                x,
    input  logic [YW-1:0]                y,
    input  logic [ADDR_WIDTH-1:0]        base,
    output logic [NPORTS*ADDR_WIDTH-1:0] addr
);

    logic [XW-1:0] col [3];
    logic [YW-1:0] row [3];

    // Wrapped neighbour coordinates: index 0 = -1, 1 = 0, 2 = +1.
    always_comb begin
        col[0] = (x == '0) ? XW'(GRID_W - 1) : x - XW'(1);
        col[1] = x;
        col[2] = (x == XW'(GRID_W - 1)) ? '0 : x + XW'(1);
        row[0] = (y == '0) ? YW'(GRID_H - 1) : y - YW'(1);
        row[1] = y;
        row[2] = (y == YW'(GRID_H - 1)) ? '0 : y + YW'(1);
    end

    always_comb begin
        addr = '0;
        for (int unsigned k = 0; k < NPORTS; k++) begin
            addr[k*ADDR_WIDTH +: ADDR_WIDTH] = base
                + ADDR_WIDTH'(row[port_row(k)]) * ADDR_WIDTH'(GRID_W)
                + ADDR_WIDTH'(col[port_col(k)]);
        end
    end

endmodule

// File: rtl/neighborhood_sweep_ctrl.sv
// Sweeps every cell of a toroidal grid for one generation: reads the 3x3 window from the
// source buffer, hands it to the compute unit, and writes the result into the other buffer.
module neighborhood_sweep_ctrl
    import neighborhood_sweep_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH      = 5,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned GRID_W     = 8,
    parameter int unsigned GRID_H     = 8,
    parameter int unsigned BUF0_BASE  = 0,
    parameter int unsigned BUF1_BASE  = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic [GEN_W-1:0]             generation,
    output logic                         src_sel,
    output logic [NPORTS*ADDR_WIDTH-1:0] mem_addr,
    output logic [NPORTS*WIDTH-1:0]      mem_data_in,
    output logic                         mem_we,
    input  logic [NPORTS*WIDTH-1:0]      mem_data_out,
    output logic [NPORTS*WIDTH-1:0]      win_data,
    output logic                         win_valid,
    input  logic                         win_ready,
    input  logic [WIDTH-1:0]             res_data,
    input  logic                         res_valid,
    output logic                         res_ready
);

    localparam int unsigned XW = (GRID_W > 1) ? $clog2(GRID_W) : 1;
    localparam int unsigned YW = (GRID_H > 1) ? $clog2(GRID_H) : 1;
    localparam logic [ADDR_WIDTH-1:0] BASE0 = ADDR_WIDTH'(BUF0_BASE);
    localparam logic [ADDR_WIDTH-1:0] BASE1 = ADDR_WIDTH'(BUF1_BASE);

    state_t                        state, state_n;
    logic [XW-1:0]                 x, x_n;
    logic [YW-1:0]                 y, y_n;
    logic                          last_cell;
    logic [ADDR_WIDTH-1:0]         src_base, dst_base, gen_base;
    logic [NPORTS*ADDR_WIDTH-1:0]  win_addr;
    logic [ADDR_WIDTH-1:0]         wr_addr;

    logic                          busy_n, done_n, mem_we_n, win_valid_n, res_ready_n, src_sel_n;
    logic [GEN_W-1:0]              generation_n;
    logic [NPORTS*ADDR_WIDTH-1:0]  mem_addr_n;
    logic [NPORTS*WIDTH-1:0]       mem_data_in_n;
    logic [NPORTS*WIDTH-1:0]       win_data_n;

    assign last_cell = (x == XW'(GRID_W - 1)) && (y == YW'(GRID_H - 1));
    assign src_base  = src_sel ? BASE1 : BASE0;
    assign dst_base  = src_sel ? BASE0 : BASE1;
    // The generator always looks at the upcoming cell; its base flips to dst for the write.
    assign gen_base  = (state_n == S_WRITE) ? dst_base : src_base;
    assign wr_addr   = win_addr[CENTRE_PORT*ADDR_WIDTH +: ADDR_WIDTH];

    neighborhood_sweep_ctrl_window_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .GRID_W     (GRID_W),
        .GRID_H     (GRID_H),
        .XW         (XW),
        .YW         (YW)
    ) u_addr_gen (
        .x    (x_n),
        .y    (y_n),
        .base (gen_base),
        .addr (win_addr)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            x     <= '0;
            y     <= '0;
        end else begin
            state <= state_n;
            x     <= x_n;
            y     <= y_n;
        end
    end

    // Next-state and cell-coordinate sequencing.
    always_comb begin
        state_n = state;
        x_n     = x;
        y_n     = y;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_ISSUE;
                    x_n     = '0;
                    y_n     = '0;
                end
            end
            S_ISSUE:   state_n = S_WAIT;
            S_WAIT:    state_n = S_CAPTURE;
            S_CAPTURE: state_n = S_OFFER;
            S_OFFER:   if (win_ready) state_n = S_RESULT;
            S_RESULT:  if (res_valid) state_n = S_WRITE;
            S_WRITE: begin
                if (last_cell) begin
                    state_n = S_DONE;
                end else begin
                    state_n = S_ISSUE;
                    if (x == XW'(GRID_W - 1)) begin
                        x_n = '0;
                        y_n = y + YW'(1);
                    end else begin
                        x_n = x + XW'(1);
                    end
                end
            end
            S_DONE:    state_n = S_IDLE;
            default:   state_n = S_IDLE;
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        busy_n        = (state_n != S_IDLE);
        done_n        = (state_n == S_DONE);
        mem_we_n      = (state_n == S_WRITE);
        win_valid_n   = (state_n == S_OFFER);
        res_ready_n   = (state_n == S_RESULT);
        src_sel_n     = src_sel;
        generation_n  = generation;
        mem_addr_n    = mem_addr;
        mem_data_in_n = mem_data_in;
        win_data_n    = win_data;

        if (state_n == S_ISSUE) begin
            mem_addr_n = win_addr;
        end
        if (state_n == S_WRITE) begin
            mem_addr_n    = {NPORTS{wr_addr}};
            mem_data_in_n = {NPORTS{res_data}};
        end
        if (state == S_CAPTURE) begin
            win_data_n = mem_data_out;
        end
        if (state == S_DONE) begin
            src_sel_n    = ~src_sel;
            generation_n = generation + GEN_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            mem_we      <= 1'b0;
            win_valid   <= 1'b0;
            res_ready   <= 1'b0;
            src_sel     <= 1'b0;
            generation  <= '0;
            mem_addr    <= '0;
            mem_data_in <= '0;
            win_data    <= '0;
        end else begin
            busy        <= busy_n;
            done        <= done_n;
            mem_we      <= mem_we_n;
            win_valid   <= win_valid_n;
            res_ready   <= res_ready_n;
            src_sel     <= src_sel_n;
            generation  <= generation_n;
            mem_addr    <= mem_addr_n;
            mem_data_in <= mem_data_in_n;
            win_data    <= win_data_n;
        end
    end

endmodule

// File: tb/tb_neighborhood_sweep_ctrl.sv
// Scoreboard bench for neighborhood_sweep_ctrl on a 4x4 grid, plus a 1x1 instance for wrap corners.
module tb_neighborhood_sweep_ctrl;
    import neighborhood_sweep_ctrl_pkg::*;

    typedef struct packed { logic [287:0] addr; logic [44:0] data; } win_exp_t;
    typedef struct packed { logic [31:0] addr; logic [4:0] data; } wr_exp_t;
    typedef struct packed { int cycles; int gen; logic src; } done_exp_t;

    logic         clk, rst, start;
    logic         busy, done, src_sel, mem_we, win_valid, win_ready, res_valid, res_ready;
    logic [15:0]  generation;
    logic [287:0] mem_addr;
    logic [44:0]  mem_data_in, mem_data_out, win_data;
    logic [4:0]   res_data;

    logic         s_start, s_busy, s_done, s_src_sel, s_mem_we, s_win_valid, s_win_ready;
    logic         s_res_valid, s_res_ready;
    logic [15:0]  s_generation;
    logic [287:0] s_mem_addr;
    logic [44:0]  s_mem_data_in, s_mem_data_out, s_win_data;
    logic [4:0]   s_res_data;

    int n_checks, n_fail, cyc, start_cyc, stall_req, stall_done;
    logic sb_en;
    win_exp_t  exp_win  [$];
    wr_exp_t   exp_wr   [$];
    done_exp_t exp_done [$];
    logic [4:0] mem [32];
    logic [4:0] rd_a [9];

    neighborhood_sweep_ctrl #(
        .WIDTH(5), .ADDR_WIDTH(32), .GRID_W(4), .GRID_H(4), .BUF0_BASE(0), .BUF1_BASE(16)
    ) dut (
        .clk(clk), .reset(rst), .start(start), .busy(busy), .done(done),
        .generation(generation), .src_sel(src_sel), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .mem_we(mem_we), .mem_data_out(mem_data_out),
        .win_data(win_data), .win_valid(win_valid), .win_ready(win_ready),
        .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready)
    );

    neighborhood_sweep_ctrl #(
        .WIDTH(5), .ADDR_WIDTH(32), .GRID_W(1), .GRID_H(1), .BUF0_BASE(5), .BUF1_BASE(6)
    ) dut_1x1 (
        .clk(clk), .reset(rst), .start(s_start), .busy(s_busy), .done(s_done),
        .generation(s_generation), .src_sel(s_src_sel), .mem_addr(s_mem_addr),
        .mem_data_in(s_mem_data_in), .mem_we(s_mem_we), .mem_data_out(s_mem_data_out),
        .win_data(s_win_data), .win_valid(s_win_valid), .win_ready(s_win_ready),
        .res_data(s_res_data), .res_valid(s_res_valid), .res_ready(s_res_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [287:0] act, input logic [287:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Memory: two-cycle read pipeline per port, write on all ports when mem_we.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) mem[i] <= 5'(i);
        end else if (mem_we) begin
            for (int k = 0; k < 9; k++) mem[mem_addr[k*32 +: 5]] <= mem_data_in[k*5 +: 5];
        end
        for (int k = 0; k < 9; k++) begin
            rd_a[k] <= mem_addr[k*32 +: 5];
            mem_data_out[k*5 +: 5] <= mem[rd_a[k]];
        end
    end

    // Compute unit: result = centre + 1; optional win_ready stall with res_valid toggling.
    initial begin
        win_ready = 1'b1;
        res_valid = 1'b1;
        res_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (win_valid && stall_done < stall_req) begin
                win_ready = 1'b0;
                res_valid = ~res_valid;
                stall_done++;
            end else begin
                win_ready = 1'b1;
                res_valid = 1'b1;
            end
            if (win_valid) res_data = win_data[20 +: 5] + 5'd1;
        end
    end

    function automatic logic [31:0] nb_addr(input int base, input int x, input int y, input int k);
        int cx, cy;
        cx = (x + (k % 3) - 1 + 4) % 4;
        cy = (y + (k / 3) - 1 + 4) % 4;
        return 32'(base + cy * 4 + cx);
    endfunction

    // Expected traffic of generation g: source cell i holds i+g-1, result is centre+1.
    task automatic push_gen(input int g, input int src, input int dst, input int cycles);
        win_exp_t  w;
        wr_exp_t   r;
        done_exp_t d;
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 4; x++) begin
                for (int k = 0; k < 9; k++) begin
                    w.addr[k*32 +: 32] = nb_addr(src, x, y, k);
                    w.data[k*5 +: 5]   = 5'(int'(nb_addr(src, x, y, k)) - src + g - 1);
                end
                exp_win.push_back(w);
                r.addr = 32'(dst + y * 4 + x);
                r.data = 5'(y * 4 + x + g);
                exp_wr.push_back(r);
            end
        end
        d.cycles = cycles;
        d.gen    = g;
        d.src    = 1'(g % 2);
        exp_done.push_back(d);
    endtask

    // Monitor: compares every handshake, write and done pulse against the queues.
    initial begin : monitor
        logic      pend;
        done_exp_t cur;
        win_exp_t  we;
        wr_exp_t   wr;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            if (sb_en) begin
                if (pend) begin
                    chk("gen_after_done", 288'(generation), 288'(cur.gen));
                    chk("src_sel_after_done", 288'(src_sel), 288'(cur.src));
                    pend = 1'b0;
                end
                if (win_valid && win_ready) begin
                    if (exp_win.size() == 0) chk("win_unexpected", 288'(1), 288'(0));
                    else begin
                        we = exp_win.pop_front();
                        chk("win_addr", mem_addr, we.addr);
                        chk("win_data", 288'(win_data), 288'(we.data));
                    end
                end
                if (win_valid && !win_ready) begin
                    chk("stall_mem_we", 288'(mem_we), 288'(0));
                    if (exp_win.size() != 0) chk("stall_win_data", 288'(win_data), 288'(exp_win[0].data));
                end
                if (res_ready) chk("res_ready_excl", 288'(win_valid), 288'(0));
                if (mem_we) begin
                    if (exp_wr.size() == 0) chk("write_unexpected", 288'(1), 288'(0));
                    else begin
                        wr = exp_wr.pop_front();
                        chk("write_addr", mem_addr, {9{wr.addr}});
                        chk("write_data", 288'(mem_data_in), 288'({9{wr.data}}));
                    end
                end
                if (done) begin
                    if (exp_done.size() == 0) chk("done_unexpected", 288'(1), 288'(0));
                    else begin
                        cur = exp_done.pop_front();
                        chk("done_cycle", 288'(cyc - start_cyc + 1), 288'(cur.cycles));
                        pend = 1'b1;
                    end
                end
            end
        end
    end

    // Cycle in which start is high counts as cycle 1.
    task automatic run_gen(input int g, input int src, input int dst, input int cycles, input bit first);
        int unsigned t0 [9] = '{15, 12, 13, 3, 0, 1, 7, 4, 5};
        push_gen(g, src, dst, cycles);
        @(negedge clk);
        start     = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        if (first) begin
            for (int i = 0; i < 20 && !win_valid; i++) @(negedge clk);
            chk("cell00_offer_seen", 288'(win_valid), 288'(1));
            for (int k = 0; k < 9; k++)
                chk("cell00_port_addr", 288'(mem_addr[k*32 +: 32]), 288'(t0[k]));
        end
        for (int i = 0; i < 400 && busy; i++) @(negedge clk);
        chk("gen_timeout_busy", 288'(busy), 288'(0));
        @(negedge clk);
    endtask

    initial begin : stim
        int s0, s_dones;
        n_checks = 0; n_fail = 0; stall_req = 0; stall_done = 0;
        sb_en = 1'b0; rst = 1'b1; start = 1'b0;
        s_start = 1'b0; s_win_ready = 1'b1; s_res_valid = 1'b1;
        s_res_data = 5'd9; s_mem_data_out = '0;
        repeat (3) @(negedge clk);
        chk("rst_generation", 288'(generation), 288'(0));
        chk("rst_busy", 288'(busy), 288'(0));
        chk("rst_win_valid", 288'(win_valid), 288'(0));
        chk("rst_mem_addr", mem_addr, 288'(0));
        chk("rst_src_sel", 288'(src_sel), 288'(0));
        rst = 1'b0;
        sb_en = 1'b1;

        run_gen(1, 0, 16, 98, 1'b1);
        for (int k = 0; k < 16; k++) chk("buf1_word", 288'(mem[16 + k]), 288'(k + 1));
        run_gen(2, 16, 0, 98, 1'b0);
        for (int k = 0; k < 16; k++) chk("buf0_word", 288'(mem[k]), 288'(k + 2));
        stall_req = stall_req + 10;
        run_gen(3, 0, 16, 108, 1'b0);

        // Reset while a window is being offered.
        sb_en = 1'b0;
        stall_req = stall_req + 20;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 20 && !win_valid; i++) @(negedge clk);
        chk("pre_reset_offer", 288'(win_valid), 288'(1));
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        chk("midrst_win_valid", 288'(win_valid), 288'(0));
        chk("midrst_mem_we", 288'(mem_we), 288'(0));
        chk("midrst_generation", 288'(generation), 288'(0));
        chk("midrst_src_sel", 288'(src_sel), 288'(0));
        chk("midrst_busy", 288'(busy), 288'(0));
        rst = 1'b0;

        // 1x1 grid: every neighbour is the cell itself; start while busy is ignored.
        s_dones = 0;
        @(negedge clk); s_start = 1'b1; s0 = cyc;
        @(negedge clk); s_start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (s_win_valid) begin
                chk("s_win_addr", s_mem_addr, {9{32'd5}});
                chk("s_win_data", 288'(s_win_data), 288'(0));
            end
            if (s_res_ready) chk("s_res_ready_excl", 288'(s_win_valid), 288'(0));
            if (s_mem_we) begin
                chk("s_write_addr", s_mem_addr, {9{32'd6}});
                chk("s_write_data", 288'(s_mem_data_in), 288'({9{5'd9}}));
            end
            if (s_done) begin
                s_dones++;
                chk("s_done_cycle", 288'(cyc - s0 + 1), 288'(8));
            end
            s_start = (i == 2);
            @(negedge clk);
        end
        chk("s_done_count", 288'(s_dones), 288'(1));
        chk("s_generation", 288'(s_generation), 288'(1));
        chk("s_busy_end", 288'(s_busy), 288'(0));
        chk("s_src_sel", 288'(s_src_sel), 288'(1));

        chk("win_queue_empty", 288'(exp_win.size()), 288'(0));
        chk("wr_queue_empty", 288'(exp_wr.size()), 288'(0));
        chk("done_queue_empty", 288'(exp_done.size()), 288'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
